// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port arbiter sharing one combinational ALU
// Round-robin on contention; each accepted operation runs IDLE -> EXEC -> DONE.
module alu_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] A0,
  input  logic [31:0] B0,
  input  logic [2:0]  op0,
  input  logic [31:0] A1,
  input  logic [31:0] B1,
  input  logic [2:0]  op1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] C_out,
  output logic        busy,
  output logic [31:0] alu_A,
  output logic [31:0] alu_B,
  output logic [2:0]  alu_ALUOp,
  input  logic [31:0] alu_C
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t      r_state;
  logic        r_last;
  logic        r_owner;
  logic        r_gnt0;
  logic        r_gnt1;
  logic        r_done0;
  logic        r_done1;
  logic [31:0] r_c_out;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [2:0]  r_alu_op;

  logic w_accept;
  logic w_win1;

  // r_last == 1 means port 1 was granted most recently, so port 0 wins a tie.
  assign w_accept = req0 | req1;
  assign w_win1   = req1 & (~req0 | ~r_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_last   <= 1'b1;
      r_owner  <= 1'b0;
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_c_out  <= 32'd0;
      r_alu_a  <= 32'd0;
      r_alu_b  <= 32'd0;
      r_alu_op <= 3'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done0 <= 1'b0;
          r_done1 <= 1'b0;
          if (w_accept) begin
            r_alu_a  <= w_win1 ? A1  : A0;
            r_alu_b  <= w_win1 ? B1  : B0;
            r_alu_op <= w_win1 ? op1 : op0;
            r_owner  <= w_win1;
            r_last   <= w_win1;
            r_gnt0   <= ~w_win1;
            r_gnt1   <= w_win1;
            r_state  <= EXEC;
          end else begin
            r_gnt0 <= 1'b0;
            r_gnt1 <= 1'b0;
          end
        end
        EXEC: begin
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_c_out <= alu_C;
          r_done0 <= ~r_owner;
          r_done1 <= r_owner;
          r_state <= DONE;
        end
        DONE: begin
          r_done0 <= 1'b0;
          r_done1 <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_done0 <= 1'b0;
          r_done1 <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign gnt0      = r_gnt0;
  assign gnt1      = r_gnt1;
  assign done0     = r_done0;
  assign done1     = r_done1;
  assign C_out     = r_c_out;
  assign busy      = (r_state != IDLE);
  assign alu_A     = r_alu_a;
  assign alu_B     = r_alu_b;
  assign alu_ALUOp = r_alu_op;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed scoreboard bench for alu_arbiter
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [31:0] A0, B0, A1, B1;
  logic [2:0]  op0, op1;
  logic        gnt0, gnt1, done0, done1, busy;
  logic [31:0] C_out, alu_A, alu_B, alu_C;
  logic [2:0]  alu_ALUOp;

  typedef struct packed {
    logic        port;
    logic [31:0] res;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Reference ALU: 0 = add, 1 = sub, anything else = and.
  always_comb begin
    alu_C = alu_A & alu_B;
    if (alu_ALUOp == 3'd0) alu_C = alu_A + alu_B;
    else if (alu_ALUOp == 3'd1) alu_C = alu_A - alu_B;
  end

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .A0(A0), .B0(B0), .op0(op0),
    .A1(A1), .B1(B1), .op1(op1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .C_out(C_out), .busy(busy),
    .alu_A(alu_A), .alu_B(alu_B), .alu_ALUOp(alu_ALUOp),
    .alu_C(alu_C)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample at the falling edge, retire any done pulse.
  task automatic step();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    chk("gnt_onehot", {31'd0, gnt0 & gnt1}, 32'd0);
    if (done0 || done1) begin
      chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("done_port", {30'd0, done1, done0}, e.port ? 32'd2 : 32'd1);
        chk("c_out", C_out, e.res);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    A0 = '0; B0 = '0; op0 = '0;
    A1 = '0; B1 = '0; op1 = '0;
    @(negedge clk);
    do_reset();
    chk("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    chk("rst_done", {30'd0, done1, done0}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cout", C_out, 32'd0);
    chk("rst_alu_a", alu_A, 32'd0);
    chk("rst_alu_b", alu_B, 32'd0);
    chk("rst_alu_op", {29'd0, alu_ALUOp}, 32'd0);

    // Single port-0 add
    req0 = 1'b1; A0 = 32'd1; B0 = 32'd2; op0 = 3'd0;
    sb.push_back('{1'b0, 32'h3});
    step();
    chk("t1_gnt0", {31'd0, gnt0}, 32'd1);
    chk("t1_gnt1", {31'd0, gnt1}, 32'd0);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_alu_a", alu_A, 32'd1);
    req0 = 1'b0;
    step();
    chk("t1_done0", {31'd0, done0}, 32'd1);
    step();
    chk("t1_idle", {31'd0, busy}, 32'd0);
    chk("t1_hold", C_out, 32'h3);

    // Contention, both held: 0,1,0,1
    do_reset();
    req0 = 1'b1; A0 = 32'd5; B0 = 32'd3; op0 = 3'd1;
    req1 = 1'b1; A1 = 32'd7; B1 = 32'd8; op1 = 3'd0;
    for (int i = 0; i < 4; i++) sb.push_back('{i[0], i[0] ? 32'd15 : 32'd2});
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_gnt", {30'd0, gnt1, gnt0}, i[0] ? 32'd2 : 32'd1);
      step();
      if (i == 3) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      step();
      chk("t2_idle", {31'd0, busy}, 32'd0);
    end
    step();
    chk("t2_stay_idle", {31'd0, busy}, 32'd0);

    // Operand change after grant must not affect the result
    req0 = 1'b1; A0 = 32'd10; B0 = 32'd20; op0 = 3'd0;
    sb.push_back('{1'b0, 32'd30});
    step();
    chk("t3_gnt0", {31'd0, gnt0}, 32'd1);
    A0 = 32'd100;
    req0 = 1'b0;
    step();
    step();

    // Port-1 subtract underflow
    req1 = 1'b1; A1 = 32'd0; B1 = 32'd1; op1 = 3'd1;
    sb.push_back('{1'b1, 32'hFFFFFFFF});
    step();
    chk("t4_gnt1", {31'd0, gnt1}, 32'd1);
    req1 = 1'b0;
    step();
    step();

    // Port 1 alone, held: grant every 3 cycles
    req1 = 1'b1; A1 = 32'd3; B1 = 32'd4; op1 = 3'd0;
    for (int i = 0; i < 3; i++) sb.push_back('{1'b1, 32'd7});
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_gnt", {30'd0, gnt1, gnt0}, 32'd2);
      if (i == 2) req1 = 1'b0;
      step();
      step();
      chk("t5_idle", {31'd0, busy}, 32'd0);
    end

    // Reset during EXEC aborts the operation
    req0 = 1'b1; A0 = 32'd9; B0 = 32'd9; op0 = 3'd0;
    step();
    chk("t6_gnt0", {31'd0, gnt0}, 32'd1);
    reset = 1'b1;
    req0 = 1'b0;
    step();
    reset = 1'b0;
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_cout", C_out, 32'd0);
    chk("t6_alu_a", alu_A, 32'd0);
    chk("t6_done0", {31'd0, done0}, 32'd0);
    step();
    step();
    step();

    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset; sampled on rising edge of clk only.
REQ-003 req0 / req1  input  1 each  level request from port 0 / port 1.
REQ-004 A0, B0 / A1, B1  input  32 each  operands of port 0 / port 1.
REQ-005 op0 / op1  input  3 each  ALUOp code of port 0 / port 1, passed to the ALU unmodified.
REQ-006 gnt0 / gnt1  output  1 each  registered one-cycle pulse: request accepted, operands latched.
REQ-007 done0 / done1  output  1 each  registered one-cycle pulse: result for that port valid on C_out.
REQ-008 C_out  output  32  registered ALU result.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 alu_A, alu_B  output  32 each  operands driven to the shared ALU, from latched registers.
REQ-011 alu_ALUOp  output  3  opcode driven to the shared ALU, from latched register.
REQ-012 alu_C  input  32  combinational ALU result.

Function
REQ-013 FSM SHALL have exactly three states: IDLE, EXEC, DONE; transitions IDLE->EXEC on accept, EXEC->DONE unconditionally, DONE->IDLE unconditionally.
REQ-014 In IDLE with only one req high, that port SHALL win; with neither high, FSM SHALL stay in IDLE.
REQ-015 In IDLE with both req high, the port not granted most recently (1-bit last pointer) SHALL win.
REQ-016 On the accepting edge: winner's A, B, op latched into alu_A, alu_B, alu_ALUOp; owner <= winner; last <= winner; state <= EXEC.
REQ-017 gnt of the owner SHALL be high for exactly the EXEC cycle; the other gnt SHALL stay low.
REQ-018 On the EXEC->DONE edge, alu_C SHALL be captured into C_out.
REQ-019 done of the owner SHALL be high for exactly the DONE cycle; C_out SHALL hold its value until the next capture.
REQ-020 Latency: req seen in IDLE cycle k -> gnt in cycle k+1 -> done and valid C_out in cycle k+2 -> IDLE in cycle k+3; maximum throughput one operation per 3 cycles.
REQ-021 req inputs and operand inputs SHALL be ignored in EXEC and DONE; operand changes after gnt SHALL NOT affect the result.
REQ-022 A port whose req remains high after its done SHALL be treated as a new request in the following IDLE cycle; with both requesting continuously, grants SHALL alternate 0,1,0,1,...
REQ-023 alu_A, alu_B, alu_ALUOp SHALL change only on an accepting edge or on reset.
REQ-024 The block SHALL perform no arithmetic; width of every data path is 32 bits with no extension or truncation.

Reset
REQ-025 When reset is high at a rising edge, state <= IDLE, last <= 1 (port 0 favoured first), owner <= 0.
REQ-026 Reset values: gnt0 = gnt1 = done0 = done1 = busy = 0, C_out = 0, alu_A = alu_B = 0, alu_ALUOp = 0.
REQ-027 Reset SHALL take priority over any request or state transition in the same cycle.
REQ-028 Reset in EXEC or DONE SHALL abort the operation: no done pulse issued afterwards, C_out = 0.

Verification (bench instantiates the team's ALU on alu_*; ALUOp 0 = add, 1 = sub)
REQ-029 Reset, then req0=1, A0=1, B0=2, op0=0 for one cycle -> gnt0 next cycle, done0 the cycle after, C_out=32'h00000003, gnt1/done1 never high.
REQ-030 Reset, then req0=req1=1 same cycle, A0=5,B0=3,op0=1, A1=7,B1=8,op1=0, held high -> port 0 first (C_out=2 with done0), then port 1 (C_out=15 with done1), grants alternate thereafter every 3 cycles.
REQ-031 req0 with A0=10,B0=20,op0=0; change A0 to 100 in the gnt0 cycle -> C_out=30 with done0.
REQ-032 req1 with A1=0,B1=1,op1=1 -> C_out=32'hFFFFFFFF with done1.
REQ-033 Only req1 held high continuously -> gnt1 every 3 cycles with no idle gap beyond the IDLE cycle; gnt0 never high.
REQ-034 Assert reset in the EXEC cycle of a port-0 operation -> next cycle busy=0, C_out=0, alu_A=0, and done0 never pulses for that operation.
